// File: rtl/sigma_pipe_if.sv
// sigma_pipe_if: valid/ready stream bundle between sigma_pipe and its neighbours
// Signals:
//   in0, in_valid, in_ready    operand stream into the unit
//   out0, out_valid, out_ready result stream out of the unit
// Modports: master = upstream/downstream side, slave = the sigma unit.
interface sigma_pipe_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in0;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out0;
    logic              out_valid;
    logic              out_ready;

    modport master (output in0, in_valid, out_ready, input in_ready, out0, out_valid);
    modport slave  (input in0, in_valid, out_ready, output in_ready, out0, out_valid);
endinterface

// File: rtl/sigma_pipe.sv
// sigma_pipe: two-stage elastic SHA sigma/Sigma unit, out = ROTR(x,A) ^ ROTR(x,B) ^ (mode ? ROTR(x,C) : SHR(x,C))
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   run               one-cycle pulse: latch amounts/mode, flush pipeline, clear count
//   constant_00..02   amounts A, B, C (low AMT_W bits used)
//   mode              0: term C is SHR, 1: term C is ROTR
//   bus               slave side of the in/out valid/ready streams
//   count             results delivered since last run or reset (wraps)
module sigma_pipe #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] constant_00,
    input  logic [31:0] constant_01,
    input  logic [31:0] constant_02,
    input  logic        mode,
    sigma_pipe_if.slave bus,
    output logic [15:0] count
);
    logic [AMT_W-1:0]  amt_a, amt_b, amt_c;
    logic              mode_r, s1_valid, s2_valid, s1_free, s2_free, take;
    logic [DATA_W-1:0] ta, tb, tc, out_r;
    logic              unused_bits;

    // Left shift by (-n mod DATA_W): n=0 becomes a zero shift, so x|x returns x.
    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [AMT_W-1:0] n);
        logic [AMT_W-1:0] l;
        l = -n;
        return (x >> n) | (x << l);
    endfunction

    assign unused_bits   = ^{constant_00[31:AMT_W], constant_01[31:AMT_W], constant_02[31:AMT_W]};
    assign s2_free       = !s2_valid || bus.out_ready;
    assign s1_free       = !s1_valid || s2_free;
    assign bus.in_ready  = s1_free && !run && !rst;
    assign take          = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out0      = out_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amt_a    <= '0;
            amt_b    <= '0;
            amt_c    <= '0;
            mode_r   <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            ta       <= '0;
            tb       <= '0;
            tc       <= '0;
            out_r    <= '0;
            count    <= '0;
        end else if (run) begin
            amt_a    <= constant_00[AMT_W-1:0];
            amt_b    <= constant_01[AMT_W-1:0];
            amt_c    <= constant_02[AMT_W-1:0];
            mode_r   <= mode;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            count    <= '0;
        end else begin
            if (s1_free) s1_valid <= take;
            if (take) begin
                ta <= rotr(bus.in0, amt_a);
                tb <= rotr(bus.in0, amt_b);
                tc <= mode_r ? rotr(bus.in0, amt_c) : bus.in0 >> amt_c;
            end
            if (s2_free) s2_valid <= s1_valid;
            if (s1_valid && s2_free) out_r <= ta ^ tb ^ tc;
            if (s2_valid && bus.out_ready) count <= count + 16'd1;
        end
    end
endmodule
